z80_bus_responder: RTL and testbench
====================================

# z80_bus_responder

Z80/R800-bus target that answers the memory, I/O and interrupt-acknowledge cycles issued by the T800 CPU core. It decodes the CPU strobes and translates each qualifying cycle into a single request/acknowledge transaction on a simple backend port. It stretches the CPU cycle with `WAIT_n` until the backend has answered, then drives read data onto the bus. It sits between the CPU core and the cartridge's RAM/ROM/peripheral fabric, and replaces the hard-coded data generator used in CPU-level benches.

## Interface
Parameters:
- `MIN_WAIT`, 1: minimum number of wait cycles inserted per serviced cycle, 0–15.
- `IO_BASE`, 8'h40: I/O port decode base, compared against `A[7:4]`.
- `IM_VECTOR`, 8'hFF: byte returned on interrupt acknowledge (RST 38h).

Ports:
- `CLK_n` in 1: system clock. All logic runs on its rising edge.
- `RESET_n` in 1: reset, synchronous, active-low.
- `A` in 16: CPU address.
- `D_in` in 8: CPU write data.
- `D_out` out 8: read data toward the CPU.
- `D_oe` out 1: enable for the `D_out` tri-state.
- `M1_n`, `MREQ_n`, `IORQ_n`, `RD_n`, `WR_n`, `RFSH_n` in 1 each: CPU strobes.
- `WAIT_n` out 1: wait request to the CPU.
- `bus_req` out 1: backend request, held high until acknowledged.
- `bus_we` out 1: 1 = write.
- `bus_io` out 1: 1 = I/O space.
- `bus_addr` out 16: backend address.
- `bus_wdata` out 8: backend write data.
- `bus_ack` in 1: one-cycle acknowledge. `bus_rdata` is valid in the same cycle.
- `bus_rdata` in 8: backend read data.

## Operation
- Cycle classes, decoded combinationally from the inputs each clock:
  - MEM: `MREQ_n`=0, `RFSH_n`=1, and (`RD_n`=0 or `WR_n`=0).
  - IO: `IORQ_n`=0, `M1_n`=1, (`RD_n`=0 or `WR_n`=0), and `A[7:4]`=`IO_BASE[7:4]`.
  - INTA: `IORQ_n`=0 and `M1_n`=0.
  - Refresh cycles and I/O cycles outside the decode range are ignored: no request, `WAIT_n`=1, `D_oe`=0.
- FSM states: IDLE, REQ, HOLD.
- IDLE:
  - A MEM or IO start moves to REQ. The cycle registers `bus_addr`=A, `bus_we`=~`WR_n`, `bus_io`, `bus_wdata`=`D_in`, and loads the wait counter with `MIN_WAIT`.
  - INTA loads `D_out`=`IM_VECTOR`, sets `D_oe`=1 and moves to HOLD with no backend request.
- REQ:
  - `bus_req`=1 and the wait counter decrements to 0.
  - A `bus_ack` latches `bus_rdata` into `D_out` on reads and records completion.
  - The FSM moves to HOLD when completion is recorded and the counter is 0.
- HOLD:
  - `D_oe`=1 while `RD_n`=0 on read cycles.
  - Return to IDLE when all of `MREQ_n`, `IORQ_n`, `RD_n` and `WR_n` are 1, which rearms the decoder. Exactly one backend transaction is issued per CPU cycle.
- Write data is captured at cycle start only. The CPU drives D before asserting `WR_n`.
- `bus_ack` outside REQ is ignored.
- If the strobes release while in REQ (CPU abort or reset), the pending request still completes. Then return directly to IDLE; the read data is discarded and `D_oe` stays 0.

## Timing
- Reset values (applied at the rising edge while `RESET_n`=0):
  - FSM state is IDLE.
  - `WAIT_n`=1, `bus_req`=0, `bus_we`=0, `bus_io`=0, `D_oe`=0, `D_out`=8'h00, `bus_addr`=0, `bus_wdata`=0.
  - Reset mid-transaction drops `bus_req` immediately. The backend must tolerate an abandoned request.
- `WAIT_n` is combinational: `WAIT_n` = ~((IDLE & MEM/IO start & (`MIN_WAIT`>0)) | (REQ & ~(done & counter==0))).
  - `WAIT_n` therefore falls in the same cycle the strobe is seen, in time for the CPU's T2 sample.
  - `WAIT_n` rises in the first cycle in which both ack and the minimum wait are satisfied.
- Request timing:
  - `bus_req` rises one clock after the cycle start.
  - Fastest read: ack in the first REQ cycle with `MIN_WAIT`=1 gives `D_out` valid 2 clocks after start.
  - `MIN_WAIT`=0 with an immediate ack gives no wait cycle.
- Ack and counter-zero arriving in the same cycle complete together.

## Structure
- Shared package `z80_bus_pkg`:
  - FSM state enum (IDLE/REQ/HOLD).
  - Cycle-class enum (NONE/MEM/IO/INTA).
  - The decode function, reused by the receiver-side monitors.
- Sub-module `z80_cycle_decoder`: purely combinational class decode plus the IO range compare. The FSM, counter and latches stay in the top module.

## Test plan
- MEM read at 16'h0003 with `MIN_WAIT`=1 and ack 3 cycles after `bus_req`, `bus_rdata`=8'h34:
  - `WAIT_n` is low for 4 cycles.
  - `D_out`=8'h34 with `D_oe`=1 until `RD_n` rises.
  - Exactly one `bus_req`.
- MEM write of 8'hA5 to 16'h8000 with immediate ack: `bus_we`=1, `bus_wdata`=8'hA5, `bus_addr`=16'h8000, and `WAIT_n` low for exactly 1 cycle.
- OUT (42h),8'h11 and IN from port 90h:
  - The first gives `bus_io`=1, `bus_addr[7:0]`=8'h42.
  - The second gives no request, `WAIT_n`=1, `D_oe`=0.
- INTA cycle: `D_out`=8'hFF, `D_oe`=1, `bus_req` never rises.
- Refresh cycle with `MREQ_n`=0 and `RFSH_n`=0: no request and `WAIT_n` stays 1. Back-to-back reads at 16'h0000 and 16'h0001 give two distinct transactions.
- `RESET_n` pulsed low while in REQ: next clock shows `bus_req`=0, `WAIT_n`=1, FSM in IDLE, and the following read is serviced normally.

Source files
------------

// File: rtl/z80_bus_pkg.sv
// Shared types for the Z80 bus responder: FSM states, cycle classes and the strobe decode.
// Combinational only; no latency, no backpressure.
// The decode function is shared with receiver-side bus monitors.
package z80_bus_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_HOLD} state_t;
    typedef enum logic [1:0] {CYC_NONE, CYC_MEM, CYC_IO, CYC_INTA} cyc_t;

    // INTA wins over the others; refresh cycles never decode as MEM.
    function automatic cyc_t decode_cycle(input logic mreq_n, input logic iorq_n,
                                          input logic m1_n, input logic rd_n,
                                          input logic wr_n, input logic rfsh_n,
                                          input logic io_hit);
        cyc_t cyc;
        cyc = CYC_NONE;
        if (!iorq_n && !m1_n)
            cyc = CYC_INTA;
        else if (!mreq_n && rfsh_n && (!rd_n || !wr_n))
            cyc = CYC_MEM;
        else if (!iorq_n && m1_n && (!rd_n || !wr_n) && io_hit)
            cyc = CYC_IO;
        return cyc;
    endfunction

endpackage

// File: rtl/z80_cycle_decoder.sv
// Classifies the current CPU strobes into NONE/MEM/IO/INTA, including the I/O port range compare.
// Purely combinational, zero latency; no backpressure.
// Only A[7:4] takes part in the I/O decode.
module z80_cycle_decoder
    import z80_bus_pkg::*;
#(
    parameter logic [7:0] IO_BASE = 8'h40
) (
    input  logic       MREQ_n,
    input  logic       IORQ_n,
    input  logic       M1_n,
    input  logic       RD_n,
    input  logic       WR_n,
    input  logic       RFSH_n,
    input  logic [3:0] io_nib,
    output cyc_t       cyc
);

    logic io_hit;

    assign io_hit = (io_nib == IO_BASE[7:4]);
    assign cyc    = decode_cycle(MREQ_n, IORQ_n, M1_n, RD_n, WR_n, RFSH_n, io_hit);

endmodule

// File: rtl/z80_bus_responder.sv
// Z80 bus target: turns each decoded MEM/IO cycle into one req/ack backend transaction, answers INTA locally.
// bus_req one clock after cycle start; read data on D_out the clock after ack + minimum wait.
// Stretches the CPU with WAIT_n until the backend acks and MIN_WAIT cycles have elapsed.
module z80_bus_responder
    import z80_bus_pkg::*;
#(
    parameter int unsigned MIN_WAIT  = 1,
    parameter logic [7:0]  IO_BASE   = 8'h40,
    parameter logic [7:0]  IM_VECTOR = 8'hFF
) (
    input  logic        CLK_n,
    input  logic        RESET_n,
    input  logic [15:0] A,
    input  logic [7:0]  D_in,
    output logic [7:0]  D_out,
    output logic        D_oe,
    input  logic        M1_n,
    input  logic        MREQ_n,
    input  logic        IORQ_n,
    input  logic        RD_n,
    input  logic        WR_n,
    input  logic        RFSH_n,
    output logic        WAIT_n,
    output logic        bus_req,
    output logic        bus_we,
    output logic        bus_io,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    input  logic        bus_ack,
    input  logic [7:0]  bus_rdata
);

    localparam logic [3:0] MIN_WAIT_L = 4'(MIN_WAIT);

    cyc_t       cyc;
    state_t     state, state_nxt;
    logic [3:0] wait_cnt, wait_cnt_nxt;
    logic       done, aborted, is_rd, is_inta;
    logic       start, ack_now, done_now, min_ok, strobes_idle;

    z80_cycle_decoder #(.IO_BASE(IO_BASE)) u_dec (
        .MREQ_n (MREQ_n),
        .IORQ_n (IORQ_n),
        .M1_n   (M1_n),
        .RD_n   (RD_n),
        .WR_n   (WR_n),
        .RFSH_n (RFSH_n),
        .io_nib (A[7:4]),
        .cyc    (cyc)
    );

    assign start        = (cyc == CYC_MEM) || (cyc == CYC_IO);
    assign strobes_idle = MREQ_n & IORQ_n & RD_n & WR_n;
    assign wait_cnt_nxt = (wait_cnt != 4'd0) ? wait_cnt - 4'd1 : 4'd0;
    // Minimum wait is met in the cycle where the counter reaches zero, not the one after.
    assign min_ok       = (wait_cnt_nxt == 4'd0);
    assign ack_now      = (state == ST_REQ) && bus_ack && !done;
    assign done_now     = done || ack_now;

    always_comb begin
        state_nxt = state;
        WAIT_n    = 1'b1;
        bus_req   = 1'b0;
        D_oe      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_REQ;
                    WAIT_n    = (MIN_WAIT_L == 4'd0);
                end else if (cyc == CYC_INTA) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_REQ: begin
                bus_req = !done;
                WAIT_n  = done_now && min_ok;
                // An abandoned CPU cycle still lets the backend finish, then skips HOLD.
                if (done_now && (aborted || strobes_idle))
                    state_nxt = ST_IDLE;
                else if (done_now && min_ok)
                    state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                D_oe = is_inta ? !IORQ_n : (is_rd && !RD_n);
                if (strobes_idle)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_n) begin
        if (!RESET_n) begin
            state     <= ST_IDLE;
            wait_cnt  <= 4'd0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            is_rd     <= 1'b0;
            is_inta   <= 1'b0;
            D_out     <= 8'h00;
            bus_addr  <= 16'h0000;
            bus_we    <= 1'b0;
            bus_io    <= 1'b0;
            bus_wdata <= 8'h00;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        bus_addr  <= A;
                        bus_we    <= !WR_n;
                        bus_io    <= (cyc == CYC_IO);
                        bus_wdata <= D_in;
                        wait_cnt  <= MIN_WAIT_L;
                        done      <= 1'b0;
                        aborted   <= 1'b0;
                        is_rd     <= WR_n;
                        is_inta   <= 1'b0;
                    end else if (cyc == CYC_INTA) begin
                        D_out   <= IM_VECTOR;
                        is_inta <= 1'b1;
                        is_rd   <= 1'b0;
                    end
                end
                ST_REQ: begin
                    wait_cnt <= wait_cnt_nxt;
                    if (ack_now) begin
                        done <= 1'b1;
                        if (!bus_we && !aborted && !strobes_idle)
                            D_out <= bus_rdata;
                    end
                    if (strobes_idle)
                        aborted <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_z80_bus_responder.sv
// Directed bench for z80_bus_responder: CPU cycle driver, delayed-ack backend and a transaction scoreboard.
module tb_z80_bus_responder;
    import z80_bus_pkg::*;

    logic        CLK_n = 1'b0;
    logic        RESET_n;
    logic [15:0] A;
    logic [7:0]  D_in, D_out;
    logic        D_oe, M1_n, MREQ_n, IORQ_n, RD_n, WR_n, RFSH_n, WAIT_n;
    logic        bus_req, bus_we, bus_io, bus_ack;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata, bus_rdata;

    // {M1_n, MREQ_n, IORQ_n, RD_n, WR_n, RFSH_n}
    localparam logic [5:0] S_IDLE  = 6'b111111;
    localparam logic [5:0] S_MEMRD = 6'b101011;
    localparam logic [5:0] S_MEMWR = 6'b101101;
    localparam logic [5:0] S_IORD  = 6'b110011;
    localparam logic [5:0] S_IOWR  = 6'b110101;
    localparam logic [5:0] S_INTA  = 6'b010111;
    localparam logic [5:0] S_RFSH  = 6'b101110;

    typedef struct packed {
        logic        we;
        logic        io;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } txn_t;

    txn_t       sb[$];
    int         vecs = 0;
    int         miscompares = 0;
    int         req_rises = 0;
    logic       prev_req = 1'b0;
    int         ack_dly = 0;
    logic [7:0] rdata_cfg = 8'h00;

    z80_bus_responder #(.MIN_WAIT(1), .IO_BASE(8'h40), .IM_VECTOR(8'hFF)) dut (
        .CLK_n(CLK_n), .RESET_n(RESET_n), .A(A), .D_in(D_in), .D_out(D_out), .D_oe(D_oe),
        .M1_n(M1_n), .MREQ_n(MREQ_n), .IORQ_n(IORQ_n), .RD_n(RD_n), .WR_n(WR_n),
        .RFSH_n(RFSH_n), .WAIT_n(WAIT_n), .bus_req(bus_req), .bus_we(bus_we),
        .bus_io(bus_io), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 CLK_n = ~CLK_n;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic txn_t mk(input logic we, input logic io, input logic [15:0] addr,
                                input logic [7:0] wd);
        txn_t t;
        t.we = we; t.io = io; t.addr = addr; t.wdata = wd;
        return t;
    endfunction

    // Backend: acks ack_dly cycles after bus_req is first seen.
    initial begin
        int age;
        age = 0;
        bus_ack = 1'b0;
        bus_rdata = 8'h00;
        forever begin
            @(posedge CLK_n); #1;
            bus_ack = 1'b0;
            if (bus_req) begin
                if (age == ack_dly) begin
                    bus_ack = 1'b1;
                    bus_rdata = rdata_cfg;
                    age = 0;
                end else begin
                    age++;
                end
            end else begin
                age = 0;
            end
        end
    end

    always @(negedge CLK_n) begin
        txn_t e;
        if (bus_req && !prev_req) req_rises++;
        prev_req = bus_req;
        if (bus_req && bus_ack) begin
            vecs++;
            assert (sb.size() != 0) else begin
                miscompares++;
                $error("FAIL unexpected_req: observed txn %0h expected none", 32'({bus_we, bus_io, bus_addr, bus_wdata}));
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("txn", 32'({bus_we, bus_io, bus_addr, bus_wdata}), 32'(e));
            end
        end
    end

    // One CPU cycle: assert strobes, hold while WAIT_n is low, one hold cycle, then release.
    task automatic cpu_cycle(input string tag, input logic [5:0] st, input logic [15:0] addr,
                             input logic [7:0] wd, input int exp_waits, input logic exp_oe,
                             input logic [7:0] exp_dout, input int exp_reqs);
        int waits, r0;
        logic oe_hold, oe_rel;
        logic [7:0] dout_hold;
        r0 = req_rises;
        waits = 0;
        @(posedge CLK_n); #1;
        A = addr; D_in = wd;
        {M1_n, MREQ_n, IORQ_n, RD_n, WR_n, RFSH_n} = st;
        for (int n = 0; n < 40; n++) begin
            @(negedge CLK_n);
            if (WAIT_n) break;
            waits++;
            @(posedge CLK_n); #1;
        end
        @(posedge CLK_n); #1;
        @(negedge CLK_n);
        oe_hold = D_oe;
        dout_hold = D_out;
        @(posedge CLK_n); #1;
        {M1_n, MREQ_n, IORQ_n, RD_n, WR_n, RFSH_n} = S_IDLE;
        @(negedge CLK_n);
        oe_rel = D_oe;
        @(posedge CLK_n); #1;
        check({tag, "_waits"}, 32'(waits), 32'(exp_waits));
        check({tag, "_reqs"}, 32'(req_rises - r0), 32'(exp_reqs));
        check({tag, "_oe_hold"}, 32'(oe_hold), 32'(exp_oe));
        if (exp_oe) check({tag, "_dout"}, 32'(dout_hold), 32'(exp_dout));
        check({tag, "_oe_release"}, 32'(oe_rel), 32'(0));
    endtask

    initial begin
        logic oe_seen;
        RESET_n = 1'b0;
        A = 16'h0000; D_in = 8'h00;
        {M1_n, MREQ_n, IORQ_n, RD_n, WR_n, RFSH_n} = S_IDLE;
        repeat (2) @(posedge CLK_n);
        @(negedge CLK_n);
        check("rst_wait_n", 32'(WAIT_n), 32'(1));
        check("rst_bus_req", 32'(bus_req), 32'(0));
        check("rst_bus_we", 32'(bus_we), 32'(0));
        check("rst_bus_io", 32'(bus_io), 32'(0));
        check("rst_d_oe", 32'(D_oe), 32'(0));
        check("rst_d_out", 32'(D_out), 32'(0));
        check("rst_bus_addr", 32'(bus_addr), 32'(0));
        check("rst_bus_wdata", 32'(bus_wdata), 32'(0));
        @(posedge CLK_n); #1;
        RESET_n = 1'b1;

        ack_dly = 3; rdata_cfg = 8'h34;
        sb.push_back(mk(1'b0, 1'b0, 16'h0003, 8'h00));
        cpu_cycle("memrd_slow", S_MEMRD, 16'h0003, 8'h00, 4, 1'b1, 8'h34, 1);

        ack_dly = 0;
        sb.push_back(mk(1'b1, 1'b0, 16'h8000, 8'hA5));
        cpu_cycle("memwr", S_MEMWR, 16'h8000, 8'hA5, 1, 1'b0, 8'h00, 1);

        sb.push_back(mk(1'b1, 1'b1, 16'h0042, 8'h11));
        cpu_cycle("out42", S_IOWR, 16'h0042, 8'h11, 1, 1'b0, 8'h00, 1);
        cpu_cycle("in90", S_IORD, 16'h0090, 8'h00, 0, 1'b0, 8'h00, 0);
        cpu_cycle("inta", S_INTA, 16'h0000, 8'h00, 0, 1'b1, 8'hFF, 0);
        cpu_cycle("rfsh", S_RFSH, 16'h0055, 8'h00, 0, 1'b0, 8'h00, 0);

        rdata_cfg = 8'h11;
        sb.push_back(mk(1'b0, 1'b0, 16'h0000, 8'h00));
        cpu_cycle("rd0", S_MEMRD, 16'h0000, 8'h00, 1, 1'b1, 8'h11, 1);
        rdata_cfg = 8'h22;
        sb.push_back(mk(1'b0, 1'b0, 16'h0001, 8'h00));
        cpu_cycle("rd1", S_MEMRD, 16'h0001, 8'h00, 1, 1'b1, 8'h22, 1);

        // CPU abandons a read while the backend is still busy.
        ack_dly = 2; rdata_cfg = 8'hEE;
        sb.push_back(mk(1'b0, 1'b0, 16'h0010, 8'h00));
        @(posedge CLK_n); #1;
        A = 16'h0010;
        {M1_n, MREQ_n, IORQ_n, RD_n, WR_n, RFSH_n} = S_MEMRD;
        @(posedge CLK_n); #1;
        {M1_n, MREQ_n, IORQ_n, RD_n, WR_n, RFSH_n} = S_IDLE;
        oe_seen = 1'b0;
        repeat (6) begin
            @(negedge CLK_n);
            oe_seen = oe_seen | D_oe;
        end
        check("abort_oe", 32'(oe_seen), 32'(0));
        check("abort_state", 32'(dut.state), 32'(ST_IDLE));
        check("abort_dout_kept", 32'(D_out), 32'(8'h22));

        // Reset pulsed while a request is outstanding.
        ack_dly = 50;
        @(posedge CLK_n); #1;
        A = 16'h1234;
        {M1_n, MREQ_n, IORQ_n, RD_n, WR_n, RFSH_n} = S_MEMRD;
        repeat (3) @(posedge CLK_n);
        @(negedge CLK_n);
        check("pre_rst_req", 32'(bus_req), 32'(1));
        @(posedge CLK_n); #1;
        RESET_n = 1'b0;
        {M1_n, MREQ_n, IORQ_n, RD_n, WR_n, RFSH_n} = S_IDLE;
        @(posedge CLK_n); #1;
        RESET_n = 1'b1;
        @(negedge CLK_n);
        check("rst_req_drop", 32'(bus_req), 32'(0));
        check("rst_req_wait", 32'(WAIT_n), 32'(1));
        check("rst_req_state", 32'(dut.state), 32'(ST_IDLE));

        ack_dly = 0; rdata_cfg = 8'h5A;
        sb.push_back(mk(1'b0, 1'b0, 16'h0002, 8'h00));
        cpu_cycle("post_rst_rd", S_MEMRD, 16'h0002, 8'h00, 1, 1'b1, 8'h5A, 1);

        repeat (2) @(posedge CLK_n);
        check("sb_empty", 32'(sb.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
